// File: rtl/ucode_pkg.sv
// Shared types and constants for the microcode sequencer: microword field
// offsets, bus operation codes, FSM states and AHB transfer encodings.
package ucode_pkg;

  // Field offsets measured from bit CTRL_W of a microword
  // {last, loop, bus_op[1:0], ctrl[CTRL_W-1:0]}.
  localparam int BUS_OP_OFS = 0;
  localparam int LOOP_OFS   = 2;
  localparam int LAST_OFS   = 3;
  localparam int HDR_W      = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_READ  = 2'b01,
    BUS_WRITE = 2'b10,
    BUS_RSVD  = 2'b11
  } bus_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  function automatic logic is_bus_op(input bus_op_e op);
    return (op == BUS_READ) || (op == BUS_WRITE);
  endfunction

endpackage

// File: rtl/ucode_store.sv
// Microcode store: one synchronous write port, one asynchronous read port.
// Contents survive reset; only writes change them.
module ucode_store #(
  parameter int UPC_W  = 7,
  parameter int WORD_W = 24
) (
  input  logic              clk,
  input  logic              we,
  input  logic [UPC_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [UPC_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**UPC_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: walks a per-opcode slot of the store, handling repeat
// loops, AHB stalls, end-of-program and slot overrun.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int CTRL_W = 20,
  parameter int ADDR_W = 5,
  parameter int UPC_W  = 7,
  parameter int CNT_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    entry_addr,
  input  logic [CNT_W-1:0]     repeat_count,
  input  logic                 hready,
  input  logic                 rom_we,
  input  logic [UPC_W-1:0]     rom_waddr,
  input  logic [CTRL_W+3:0]    rom_wdata,
  output logic                 ready,
  output logic                 valid_out,
  output logic [CTRL_W-1:0]    ctrl_out,
  output logic [1:0]           htrans,
  output logic                 hwrite,
  output logic                 done,
  output logic                 seq_err
);

  localparam int SLOT_W = UPC_W - ADDR_W;
  localparam int WORD_W = CTRL_W + HDR_W;
  localparam logic [UPC_W-1:0] UPC_ONE = {{(UPC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_reg, state_next;
  logic [UPC_W-1:0]   upc_reg, upc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic               first_reg, first_next;

  logic [WORD_W-1:0]  word;
  logic [CTRL_W-1:0]  word_ctrl;
  logic               word_last;
  logic               word_loop;
  bus_op_e            word_bus;
  logic               store_we;
  logic               run;
  logic               bus_word;
  logic               advance;
  logic               skip;
  logic               hold;
  logic               end_of_slot;

  // The store is only writable while no program is fetching from it.
  assign store_we = rom_we && (state_reg == ST_IDLE);

  ucode_store #(
    .UPC_W  (UPC_W),
    .WORD_W (WORD_W)
  ) u_store (
    .clk   (clk),
    .we    (store_we),
    .waddr (rom_waddr),
    .wdata (rom_wdata),
    .raddr (upc_reg),
    .rdata (word)
  );

  assign word_ctrl = word[CTRL_W-1:0];
  assign word_last = word[CTRL_W+LAST_OFS];
  assign word_loop = word[CTRL_W+LOOP_OFS];
  assign word_bus  = bus_op_e'(word[CTRL_W+BUS_OP_OFS+1 : CTRL_W+BUS_OP_OFS]);

  assign run         = (state_reg == ST_RUN);
  assign bus_word    = run && is_bus_op(word_bus);
  assign advance     = run && (!is_bus_op(word_bus) || hready);
  assign skip        = word_loop && (cnt_reg == '0);
  // A loop word with more than one iteration left stays at the same upc.
  assign hold        = word_loop && (cnt_reg > CNT_ONE);
  assign end_of_slot = &upc_reg[SLOT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      upc_reg   <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      upc_reg   <= upc_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      first_reg <= first_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    upc_next   = upc_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    err_next   = err_reg;
    first_next = first_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          upc_next   = {entry_addr, {SLOT_W{1'b0}}};
          cnt_next   = repeat_count;
          first_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (advance) begin
          first_next = 1'b0;
          if (word_loop && !skip) begin
            cnt_next = cnt_reg - CNT_ONE;
          end
          if (!hold) begin
            if (word_last) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end else if (end_of_slot) begin
              // Ran off the end of the slot without a last word.
              state_next = ST_IDLE;
              err_next   = 1'b1;
            end else begin
              upc_next = upc_reg + UPC_ONE;
            end
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ready     = (state_reg == ST_IDLE);
    valid_out = first_reg && advance;
    ctrl_out  = '0;
    htrans    = HTRANS_IDLE;
    hwrite    = 1'b0;
    if (advance && !skip) begin
      ctrl_out = word_ctrl;
    end
    // Transfer type is held through stalls so the slave sees a stable request.
    if (bus_word) begin
      htrans = HTRANS_NONSEQ;
      hwrite = (word_bus == BUS_WRITE);
    end
  end

  assign done    = done_reg;
  assign seq_err = err_reg;

endmodule
